// File: rtl/rf_pkg.sv
// Shared register-file types and writeback requester indices.
// Imported by the writeback scheduler and its arbiter.
package rf_pkg;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 4;
  localparam int NUM_REG = 2**ADDR_W;

  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the flop remembers the
// requester that last completed a handshake.
module rr_arbiter2
  import rf_pkg::*;
(
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [1:0] i_req,
  output logic [1:0] o_grant
);

  logic r_last;

  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = r_last ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

  // A grant always coincides with a valid, so it is the handshake.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_last <= 1'b1;
    end else if (|o_grant) begin
      r_last <= o_grant[REQ_MEM];
    end
  end

endmodule

// File: rtl/reg_file_wb_scheduler.sv
// Writeback port sharing, busy scoreboard and
// read-hazard detection for the register file.
module reg_file_wb_scheduler
  import rf_pkg::*;
(
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_wb0_valid,
  input  reg_idx_t           i_wb0_rd,
  input  reg_data_t          i_wb0_data,
  output logic               o_wb0_ready,
  input  logic               i_wb1_valid,
  input  reg_idx_t           i_wb1_rd,
  input  reg_data_t          i_wb1_data,
  output logic               o_wb1_ready,
  input  logic               i_issue_valid,
  input  reg_idx_t           i_issue_rd,
  input  reg_idx_t           i_rs1,
  input  reg_idx_t           i_rs2,
  output logic               o_hazard,
  output logic [NUM_REG-1:0] o_busy,
  output logic               o_rf_write,
  output reg_idx_t           o_rf_rd,
  output reg_data_t          o_rf_writedata,
  output logic               o_wb_err
);

  logic [1:0]         w_grant;
  logic               w_hs;
  reg_idx_t           w_rd;
  reg_data_t          w_data;
  logic               w_commit;
  logic [NUM_REG-1:0] w_set;
  logic [NUM_REG-1:0] w_clr;
  logic [NUM_REG-1:0] w_busy_nxt;

  logic [NUM_REG-1:0] r_busy;
  logic               r_rf_write;
  reg_idx_t           r_rf_rd;
  reg_data_t          r_rf_data;
  logic               r_err;

  rr_arbiter2 u_arb (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_req   ({i_wb1_valid, i_wb0_valid}),
    .o_grant (w_grant)
  );

  assign o_wb0_ready = w_grant[REQ_ALU];
  assign o_wb1_ready = w_grant[REQ_MEM];
  assign w_hs        = |w_grant;

  assign w_rd   = w_grant[REQ_MEM] ? i_wb1_rd : i_wb0_rd;
  assign w_data = w_grant[REQ_MEM] ? i_wb1_data : i_wb0_data;

  assign w_commit = w_hs && (w_rd != '0);

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (i_issue_valid && i_issue_rd != '0) begin
      w_set[i_issue_rd] = 1'b1;
    end
    if (w_commit) begin
      w_clr[w_rd] = 1'b1;
    end
  end

  // Set after clear: a newer producer keeps the register pending.
  assign w_busy_nxt = ((r_busy & ~w_clr) | w_set)
                    & ~NUM_REG'(1);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_busy     <= '0;
      r_rf_write <= 1'b0;
      r_rf_rd    <= '0;
      r_rf_data  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_rf_write <= w_commit;
      if (w_hs) begin
        r_rf_rd   <= w_rd;
        r_rf_data <= w_data;
      end
      if (w_commit && !r_busy[w_rd]) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_hazard = ((i_rs1 != '0) && r_busy[i_rs1])
                 || ((i_rs2 != '0) && r_busy[i_rs2]);

  assign o_busy         = r_busy;
  assign o_rf_write     = r_rf_write;
  assign o_rf_rd        = r_rf_rd;
  assign o_rf_writedata = r_rf_data;
  assign o_wb_err       = r_err;

endmodule

// File: tb/tb_reg_file_wb_scheduler.sv
// Directed bench for reg_file_wb_scheduler.
// Expected values are written out by hand below.
module tb_reg_file_wb_scheduler;
  import rf_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               wb0_valid = 1'b0;
  reg_idx_t           wb0_rd = '0;
  reg_data_t          wb0_data = '0;
  logic               wb0_ready;
  logic               wb1_valid = 1'b0;
  reg_idx_t           wb1_rd = '0;
  reg_data_t          wb1_data = '0;
  logic               wb1_ready;
  logic               issue_valid = 1'b0;
  reg_idx_t           issue_rd = '0;
  reg_idx_t           rs1 = '0;
  reg_idx_t           rs2 = '0;
  logic               hazard;
  logic [NUM_REG-1:0] busy;
  logic               rf_write;
  reg_idx_t           rf_rd;
  reg_data_t          rf_wdata;
  logic               wb_err;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_file_wb_scheduler dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_wb0_valid    (wb0_valid),
    .i_wb0_rd       (wb0_rd),
    .i_wb0_data     (wb0_data),
    .o_wb0_ready    (wb0_ready),
    .i_wb1_valid    (wb1_valid),
    .i_wb1_rd       (wb1_rd),
    .i_wb1_data     (wb1_data),
    .o_wb1_ready    (wb1_ready),
    .i_issue_valid  (issue_valid),
    .i_issue_rd     (issue_rd),
    .i_rs1          (rs1),
    .i_rs2          (rs2),
    .o_hazard       (hazard),
    .o_busy         (busy),
    .o_rf_write     (rf_write),
    .o_rf_rd        (rf_rd),
    .o_rf_writedata (rf_wdata),
    .o_wb_err       (wb_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #3;
    chk("rst_wr",   32'(rf_write), 32'd0);
    chk("rst_rd",   32'(rf_rd),    32'd0);
    chk("rst_data", 32'(rf_wdata), 32'd0);
    chk("rst_busy", 32'(busy),     32'd0);
    chk("rst_err",  32'(wb_err),   32'd0);
    tick();
    tick();
    rst = 1'b1;

    // mid-stream reset drops the pending request
    issue_valid = 1'b1; issue_rd = 4'd3;
    tick();
    issue_valid = 1'b0;
    chk("t1_busy3", 32'(busy), 32'h0008);
    wb0_valid = 1'b1; wb0_rd = 4'd3; wb0_data = 16'hAAAA;
    #1;
    chk("t1_rdy", 32'(wb0_ready), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("t1_wr0",   32'(rf_write), 32'd0);
    chk("t1_busy0", 32'(busy),     32'd0);
    chk("t1_err0",  32'(wb_err),   32'd0);
    wb0_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("t1_nowr", 32'(rf_write), 32'd0);

    // alternating grants under contention
    issue_valid = 1'b1; issue_rd = 4'd1;
    tick();
    issue_rd = 4'd2;
    tick();
    issue_valid = 1'b0;
    chk("t3_busy", 32'(busy), 32'h0006);
    wb0_valid = 1'b1; wb0_rd = 4'd1; wb0_data = 16'h1111;
    wb1_valid = 1'b1; wb1_rd = 4'd2; wb1_data = 16'h2222;
    #1;
    chk("t3_g1", 32'({wb1_ready, wb0_ready}), 32'b01);
    tick();
    chk("t3_c1", 32'({rf_write, rf_rd, rf_wdata}), 32'h11_1111);
    chk("t3_b1", 32'(busy), 32'h0004);
    issue_valid = 1'b1; issue_rd = 4'd1;
    #1;
    chk("t3_g2", 32'({wb1_ready, wb0_ready}), 32'b10);
    tick();
    chk("t3_c2", 32'({rf_write, rf_rd, rf_wdata}), 32'h12_2222);
    chk("t3_b2", 32'(busy), 32'h0002);
    issue_rd = 4'd2;
    #1;
    chk("t3_g3", 32'({wb1_ready, wb0_ready}), 32'b01);
    tick();
    chk("t3_c3", 32'({rf_write, rf_rd, rf_wdata}), 32'h11_1111);
    chk("t3_b3", 32'(busy), 32'h0004);
    issue_valid = 1'b0;
    #1;
    chk("t3_g4", 32'({wb1_ready, wb0_ready}), 32'b10);
    tick();
    chk("t3_c4", 32'({rf_write, rf_rd, rf_wdata}), 32'h12_2222);
    chk("t3_b4", 32'(busy), 32'h0000);
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    chk("t3_err", 32'(wb_err), 32'd0);

    // single ALU commit
    issue_valid = 1'b1; issue_rd = 4'd5;
    tick();
    issue_valid = 1'b0;
    chk("t2_busy5", 32'(busy), 32'h0020);
    wb0_valid = 1'b1; wb0_rd = 4'd5; wb0_data = 16'hBEEF;
    #1;
    chk("t2_rdy", 32'({wb1_ready, wb0_ready}), 32'b01);
    tick();
    wb0_valid = 1'b0;
    chk("t2_wr",   32'(rf_write), 32'd1);
    chk("t2_rd",   32'(rf_rd),    32'd5);
    chk("t2_data", 32'(rf_wdata), 32'hBEEF);
    chk("t2_busy", 32'(busy),     32'h0000);
    tick();
    chk("t2_idle", 32'(rf_write), 32'd0);

    // hazard tracking
    issue_valid = 1'b1; issue_rd = 4'd7;
    tick();
    issue_valid = 1'b0;
    rs1 = 4'd7;
    #1;
    chk("t4_hz1", 32'(hazard), 32'd1);
    tick();
    chk("t4_hz2", 32'(hazard), 32'd1);
    wb0_valid = 1'b1; wb0_rd = 4'd7; wb0_data = 16'h0707;
    #1;
    chk("t4_hz3", 32'(hazard), 32'd1);
    tick();
    wb0_valid = 1'b0;
    chk("t4_cm", 32'({rf_write, rf_rd}), 32'h17);
    chk("t4_hz4", 32'(hazard), 32'd0);
    for (int i = 1; i < NUM_REG; i++) begin
      issue_valid = 1'b1;
      issue_rd = reg_idx_t'(i);
      tick();
    end
    issue_valid = 1'b0;
    chk("t4_all", 32'(busy), 32'hFFFE);
    rs1 = 4'd0; rs2 = 4'd0;
    #1;
    chk("t4_hz0", 32'(hazard), 32'd0);
    rs2 = 4'd15;
    #1;
    chk("t4_hz15", 32'(hazard), 32'd1);
    rs2 = 4'd0;
    issue_valid = 1'b1; issue_rd = 4'd7;
    wb0_valid = 1'b1; wb0_rd = 4'd7; wb0_data = 16'h7777;
    tick();
    issue_valid = 1'b0; wb0_valid = 1'b0;
    chk("t4_setwin", 32'(busy), 32'hFFFE);
    chk("t4_wr7", 32'({rf_write, rf_rd}), 32'h17);

    // rd==0 and commit to idle register
    rst_pulse();
    wb1_valid = 1'b1; wb1_rd = 4'd0; wb1_data = 16'h1234;
    #1;
    chk("t5_rdy1", 32'(wb1_ready), 32'd1);
    tick();
    wb1_valid = 1'b0;
    chk("t5_wr0",  32'(rf_write), 32'd0);
    chk("t5_bz0",  32'(busy),     32'h0000);
    chk("t5_err0", 32'(wb_err),   32'd0);
    wb0_valid = 1'b1; wb0_rd = 4'd9; wb0_data = 16'h9999;
    tick();
    wb0_valid = 1'b0;
    chk("t5_wr9", 32'({rf_write, rf_rd, rf_wdata}), 32'h19_9999);
    chk("t5_err1", 32'(wb_err), 32'd1);
    tick();
    tick();
    chk("t5_errk", 32'(wb_err), 32'd1);
    chk("t5_idle", 32'(rf_write), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
